mfc_frame_scheduler: RTL and testbench

//  Sits between MFCC front end and DNN_main/DP_main; collects per-frame MFCC coefficients into a 2-bank frame buffer.

---
 rtl/dnn_dp_pkg.sv | 24 ++
 rtl/frame_bank_ram.sv | 48 ++++
 rtl/mfc_frame_scheduler.sv | 243 ++++++++++++++++++++++++
 tb/tb_mfc_frame_scheduler.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dnn_dp_pkg.sv
// Shared definitions for the MFCC frame scheduler.
// Holds the default coefficient geometry, the read-side FSM encoding,
// the per-bank occupancy constants and a saturating counter helper.
package dnn_dp_pkg;

  localparam int DW_DEF    = 32;
  localparam int IW_DEF    = 5;
  localparam int NCOEF_DEF = 26;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_WAIT_DNN = 2'd2
  } rd_state_e;

  localparam logic BANK_EMPTY = 1'b0;
  localparam logic BANK_FULL  = 1'b1;

  // 8-bit increment that sticks at 255.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : (v + 8'd1);
  endfunction

endpackage

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame buffer RAM with a registered read port.
// The bank select is the address MSB, so each bank spans 2**(AW-1) words
// of which only the first NCOEF are used.
// Ports:
//   clk      in   clock
//   i_rst_n  in   async active-low reset (read register only)
//   i_we     in   write enable
//   i_waddr  in   AW  write address {bank, index}
//   i_wdata  in   DW  write data
//   i_re     in   read enable
//   i_raddr  in   AW  read address {bank, index}
//   o_rdata  out  DW  registered read data
module frame_bank_ram #(
  parameter int DW = 32,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          i_rst_n,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Storage array write port (no reset on the array itself).
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Registered read port; cleared on reset so the output starts at zero.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rdata <= {DW{1'b0}};
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mfc_frame_scheduler.sv
// MFCC frame scheduler between the MFCC front end and DNN_main / DP_main.
// Collects one frame of coefficients into a 2-bank buffer, streams each
// complete frame to the DNN as a contiguous burst, waits for the DNN result
// (or a timeout), gates silence by VAD with a hangover and tells DP_main
// when an utterance has closed.
// Ports:
//   clk, reset          clock, async active-low reset
//   mfc_i/mfc_index/mfc_dv/vad_i   coefficient input stream with VAD flag
//   dnn_vec_o/dnn_dv_o  coefficient burst to DNN_main
//   dnn_done_i          DNN_main frame result strobe
//   dp_vad_o            VAD tag of the frame last sent
//   dp_clear_o          one-cycle utterance-closed pulse
//   frame_cnt_o         frames forwarded (wraps)
//   drop_cnt_o          frames dropped on overflow / sequence error (saturates)
//   ovf_o, timeout_o    sticky overflow / DNN timeout flags
module mfc_frame_scheduler
  import dnn_dp_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int IW      = IW_DEF,
  parameter int NCOEF   = NCOEF_DEF,
  parameter int HANG    = 8,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] mfc_i,
  input  logic [IW-1:0] mfc_index,
  input  logic          mfc_dv,
  input  logic          vad_i,
  output logic [DW-1:0] dnn_vec_o,
  output logic          dnn_dv_o,
  input  logic          dnn_done_i,
  output logic          dp_vad_o,
  output logic          dp_clear_o,
  output logic [15:0]   frame_cnt_o,
  output logic [7:0]    drop_cnt_o,
  output logic          ovf_o,
  output logic          timeout_o
);

  localparam int HW = (HANG > 0) ? $clog2(HANG + 1) : 1;
  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0] WR_LAST = IW'(NCOEF - 1);
  localparam logic [IW:0]   RD_LAST = (IW + 1)'(NCOEF);
  localparam logic [HW-1:0] HANG_W  = HW'(HANG);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  // write side state
  logic          r_wr_bank;
  logic          r_filling;
  logic [IW-1:0] r_expect;
  logic          r_cur_tag;
  logic [1:0]    r_bank_tag;
  logic [HW-1:0] r_hang;
  logic [7:0]    r_drop_cnt;
  logic          r_ovf;
  // read side state
  rd_state_e     r_state;
  logic          r_rd_bank;
  logic [1:0]    r_full;
  logic [IW:0]   r_rd_idx;
  logic [TW-1:0] r_to;
  logic          r_dnn_dv;
  logic          r_dp_vad;
  logic          r_dp_clear;
  logic          r_utt_open;
  logic [15:0]   r_frame_cnt;
  logic          r_timeout;

  logic          w_idx0, w_voice, w_start_keep, w_start_ovf;
  logic          w_in_seq, w_seq_err, w_last;
  logic [1:0]    w_set, w_clr;
  rd_state_e     w_state_n;
  logic          w_rd_en, w_to_hit, w_clear;
  logic [DW-1:0] w_rdata;

  // Write-side decode. A silent frame (tag 0, hangover expired) is ignored
  // before the bank-full check, so gated silence never counts as overflow.
  always_comb begin
    w_idx0       = mfc_dv && (mfc_index == {IW{1'b0}});
    w_voice      = vad_i || (r_hang != {HW{1'b0}});
    w_start_keep = w_idx0 && w_voice && !(&r_full);
    w_start_ovf  = w_idx0 && w_voice && (&r_full);
    w_in_seq     = mfc_dv && r_filling && !w_idx0 && (mfc_index == r_expect);
    w_seq_err    = mfc_dv && r_filling && !w_idx0 && (mfc_index != r_expect);
    w_last       = w_in_seq && (mfc_index == WR_LAST);
    w_set        = 2'b00;
    if (w_last) begin
      w_set[r_wr_bank] = BANK_FULL;
    end else begin
      w_set = 2'b00;
    end
  end

  // Write sequencer, VAD hangover, drop/overflow accounting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_bank  <= 1'b0;
      r_filling  <= 1'b0;
      r_expect   <= {IW{1'b0}};
      r_cur_tag  <= 1'b0;
      r_bank_tag <= 2'b00;
      r_hang     <= {HW{1'b0}};
      r_drop_cnt <= 8'd0;
      r_ovf      <= 1'b0;
    end else begin
      if (w_start_keep) begin
        r_filling <= 1'b1;
        r_expect  <= {{(IW-1){1'b0}}, 1'b1};
        r_cur_tag <= vad_i;
        r_hang    <= vad_i ? HANG_W : (r_hang - 1'b1);
      end else if (w_idx0) begin
        // overflow or gated silence: ignore the rest of this frame
        r_filling <= 1'b0;
        r_expect  <= {IW{1'b0}};
        if (w_start_ovf) begin
          r_ovf      <= 1'b1;
          r_drop_cnt <= sat_inc8(r_drop_cnt);
        end
      end else if (w_in_seq) begin
        if (w_last) begin
          r_filling             <= 1'b0;
          r_expect              <= {IW{1'b0}};
          r_bank_tag[r_wr_bank] <= r_cur_tag;
          r_wr_bank             <= ~r_wr_bank;
        end else begin
          r_expect <= r_expect + 1'b1;
        end
      end else if (w_seq_err) begin
        r_filling  <= 1'b0;
        r_expect   <= {IW{1'b0}};
        r_drop_cnt <= sat_inc8(r_drop_cnt);
      end
    end
  end

  // Read FSM next state; the RAM read for word 0 is issued while still in
  // IDLE so the first word appears two cycles after the frame completes.
  always_comb begin
    w_state_n = r_state;
    w_rd_en   = 1'b0;
    w_clr     = 2'b00;
    w_to_hit  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_full[r_rd_bank] == BANK_FULL) begin
          w_state_n = ST_SEND;
          w_rd_en   = 1'b1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (r_rd_idx == RD_LAST) begin
          w_state_n = ST_WAIT_DNN;
        end else begin
          w_rd_en = 1'b1;
        end
      end
      ST_WAIT_DNN: begin
        if (dnn_done_i || (r_to == TO_LAST)) begin
          w_state_n        = ST_IDLE;
          w_clr[r_rd_bank] = 1'b1;
          w_to_hit         = !dnn_done_i;
        end else begin
          w_state_n = ST_WAIT_DNN;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase
  end

  // Utterance close: hangover expired, nothing buffered, being written or in flight.
  always_comb begin
    w_clear = r_utt_open && (r_hang == {HW{1'b0}}) && (r_state == ST_IDLE) &&
              (r_full == {2{BANK_EMPTY}}) && !r_filling && !w_start_keep;
  end

  // Read FSM state, bank occupancy, burst output and counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rd_bank   <= 1'b0;
      r_full      <= {2{BANK_EMPTY}};
      r_rd_idx    <= {(IW+1){1'b0}};
      r_to        <= {TW{1'b0}};
      r_dnn_dv    <= 1'b0;
      r_dp_vad    <= 1'b0;
      r_dp_clear  <= 1'b0;
      r_utt_open  <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_timeout   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_dnn_dv   <= w_rd_en;
      r_dp_clear <= w_clear;
      // fill and release touch different banks, so both apply in one cycle
      r_full     <= (r_full & ~w_clr) | w_set;
      r_rd_idx   <= w_rd_en ? (r_rd_idx + 1'b1) : {(IW+1){1'b0}};
      r_to       <= (r_state == ST_WAIT_DNN) ? (r_to + 1'b1) : {TW{1'b0}};
      if ((r_state == ST_IDLE) && w_rd_en) begin
        r_dp_vad <= r_bank_tag[r_rd_bank];
      end
      if ((r_state == ST_SEND) && (w_state_n == ST_WAIT_DNN)) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
        r_utt_open  <= 1'b1;
      end else if (w_clear) begin
        r_utt_open <= 1'b0;
      end
      if (|w_clr) begin
        r_rd_bank <= ~r_rd_bank;
      end
      if (w_to_hit) begin
        r_timeout <= 1'b1;
      end
    end
  end

  frame_bank_ram #(
    .DW (DW),
    .AW (IW + 1)
  ) u_ram (
    .clk     (clk),
    .i_rst_n (reset),
    .i_we    (w_start_keep || w_in_seq),
    .i_waddr ({r_wr_bank, mfc_index}),
    .i_wdata (mfc_i),
    .i_re    (w_rd_en),
    .i_raddr ({r_rd_bank, r_rd_idx[IW-1:0]}),
    .o_rdata (w_rdata)
  );

  assign dnn_vec_o   = w_rdata;
  assign dnn_dv_o    = r_dnn_dv;
  assign dp_vad_o    = r_dp_vad;
  assign dp_clear_o  = r_dp_clear;
  assign frame_cnt_o = r_frame_cnt;
  assign drop_cnt_o  = r_drop_cnt;
  assign ovf_o       = r_ovf;
  assign timeout_o   = r_timeout;

endmodule

// File: tb/tb_mfc_frame_scheduler.sv
// Directed bench for mfc_frame_scheduler with a word/tag scoreboard and an
// automatic DNN completion responder.
module tb_mfc_frame_scheduler;

  localparam int NCOEF = 26;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mfc_i;
  logic [4:0]  mfc_index;
  logic        mfc_dv;
  logic        vad_i;
  logic [31:0] dnn_vec_o;
  logic        dnn_dv_o;
  logic        dnn_done_i;
  logic        dp_vad_o;
  logic        dp_clear_o;
  logic [15:0] frame_cnt_o;
  logic [7:0]  drop_cnt_o;
  logic        ovf_o;
  logic        timeout_o;

  mfc_frame_scheduler dut (
    .clk         (clk),
    .reset       (reset),
    .mfc_i       (mfc_i),
    .mfc_index   (mfc_index),
    .mfc_dv      (mfc_dv),
    .vad_i       (vad_i),
    .dnn_vec_o   (dnn_vec_o),
    .dnn_dv_o    (dnn_dv_o),
    .dnn_done_i  (dnn_done_i),
    .dp_vad_o    (dp_vad_o),
    .dp_clear_o  (dp_clear_o),
    .frame_cnt_o (frame_cnt_o),
    .drop_cnt_o  (drop_cnt_o),
    .ovf_o       (ovf_o),
    .timeout_o   (timeout_o)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] word;
    logic        tag;
  } sb_t;

  sb_t sb_q[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  last_cyc = 0;
  int  first_dv_cyc = 0;
  int  burst_len = 0;
  int  done_at = 0;
  int  done_delay = 40;
  int  clear_cnt = 0;
  int  clear_fc = 0;
  bit  in_burst = 1'b0;
  bit  pend = 1'b0;
  bit  auto_done = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard per burst word, checks burst length,
  // counts dp_clear pulses and answers each burst with dnn_done_i.
  initial begin : monitor
    sb_t e;
    dnn_done_i = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        dnn_done_i = 1'b0;
        in_burst   = 1'b0;
        burst_len  = 0;
        pend       = 1'b0;
        continue;
      end
      dnn_done_i = 1'b0;
      if (pend && auto_done && (cyc >= done_at)) begin
        dnn_done_i = 1'b1;
        pend       = 1'b0;
      end
      if (dp_clear_o) begin
        clear_cnt++;
        clear_fc = 32'(frame_cnt_o);
      end
      if (dnn_dv_o) begin
        if (!in_burst) begin
          in_burst     = 1'b1;
          burst_len    = 0;
          first_dv_cyc = cyc;
        end
        burst_len++;
        if (sb_q.size() == 0) begin
          check("unexpected_word", dnn_vec_o, 32'hDEAD_BEEF);
        end else begin
          e = sb_q.pop_front();
          check("dnn_vec", dnn_vec_o, e.word);
          check("dp_vad", 32'(dp_vad_o), 32'(e.tag));
        end
      end else if (in_burst) begin
        in_burst = 1'b0;
        check("burst_len", 32'(burst_len), 32'(NCOEF));
        pend    = 1'b1;
        done_at = cyc + done_delay;
      end
    end
  end

  task automatic drive_word(input int idx, input logic [31:0] w, input logic v);
    @(negedge clk);
    mfc_dv    = 1'b1;
    mfc_index = idx[4:0];
    mfc_i     = w;
    vad_i     = v;
  endtask

  task automatic idle_bus();
    @(negedge clk);
    mfc_dv = 1'b0;
  endtask

  task automatic send_frame(input logic v, input bit fwd);
    logic [31:0] w;
    for (int k = 0; k < NCOEF; k++) begin
      w = $urandom;
      drive_word(k, w, v);
      if (fwd) sb_q.push_back('{word: w, tag: v});
      if (k == NCOEF - 1) last_cyc = cyc;
    end
    idle_bus();
  endtask

  task automatic wait_idle(input int max, input string tag);
    int n = 0;
    while ((n < max) && ((sb_q.size() != 0) || in_burst || pend)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_drain"}, 32'(n < max), 32'd1);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_burst_end(input int max, input string tag);
    int n = 0;
    while ((n < max) && ((sb_q.size() != 0) || in_burst)) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_burst_end"}, 32'(n < max), 32'd1);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    reset = 1'b0; mfc_dv = 1'b0; mfc_i = 32'd0; mfc_index = 5'd0; vad_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dv", 32'(dnn_dv_o), 32'd0);
    check("rst_vec", dnn_vec_o, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt_o), 32'd0);
    check("rst_drop_cnt", 32'(drop_cnt_o), 32'd0);
    check("rst_flags", {28'd0, ovf_o, timeout_o, dp_vad_o, dp_clear_o}, 32'd0);
    reset = 1'b1;

    // single voiced frame, latency and frame count
    send_frame(1'b1, 1'b1);
    wait_idle(400, "t1");
    check("t1_latency", 32'(first_dv_cyc), 32'(last_cyc + 2));
    check("t1_frame_cnt", 32'(frame_cnt_o), 32'd1);
    check("t1_dp_vad", 32'(dp_vad_o), 32'd1);

    // three back-to-back frames with DNN stalled: third overflows
    auto_done = 1'b0;
    send_frame(1'b1, 1'b1);
    send_frame(1'b1, 1'b1);
    send_frame(1'b1, 1'b0);
    repeat (5) @(negedge clk);
    check("t2_ovf", 32'(ovf_o), 32'd1);
    check("t2_drop", 32'(drop_cnt_o), 32'd1);
    check("t2_frame_cnt_stalled", 32'(frame_cnt_o), 32'd2);
    auto_done = 1'b1;
    wait_idle(600, "t2");
    check("t2_frame_cnt", 32'(frame_cnt_o), 32'd3);

    // sequence error discards a partial frame
    drive_word(0, 32'h1111_0000, 1'b1);
    drive_word(1, 32'h1111_0001, 1'b1);
    drive_word(2, 32'h1111_0002, 1'b1);
    drive_word(5, 32'h1111_0005, 1'b1);
    idle_bus();
    send_frame(1'b1, 1'b1);
    wait_idle(400, "t3");
    check("t3_drop", 32'(drop_cnt_o), 32'd2);
    check("t3_frame_cnt", 32'(frame_cnt_o), 32'd4);
    check("t3_no_clear", 32'(clear_cnt), 32'd0);

    // hangover: 2 voiced + 12 silent, HANG=8 -> 10 sent, one clear
    for (int f = 0; f < 14; f++) begin
      send_frame(f < 2, f < 10);
      wait_idle(400, "t4");
    end
    check("t4_frame_cnt", 32'(frame_cnt_o), 32'd14);
    check("t4_drop", 32'(drop_cnt_o), 32'd2);
    check("t4_clear_cnt", 32'(clear_cnt), 32'd1);
    check("t4_clear_after_last", 32'(clear_fc), 32'd14);
    check("t4_dp_vad", 32'(dp_vad_o), 32'd0);

    // DNN never answers: timeout release, then next frame still sent
    auto_done = 1'b0;
    send_frame(1'b1, 1'b1);
    wait_burst_end(200, "t5");
    check("t5_frame_cnt", 32'(frame_cnt_o), 32'd15);
    repeat (4000) @(negedge clk);
    check("t5_timeout_early", 32'(timeout_o), 32'd0);
    repeat (200) @(negedge clk);
    check("t5_timeout", 32'(timeout_o), 32'd1);
    auto_done = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(1'b1, 1'b1);
    wait_idle(400, "t5b");
    check("t5_frame_cnt_next", 32'(frame_cnt_o), 32'd16);
    check("t5_timeout_sticky", 32'(timeout_o), 32'd1);

    // reset in the middle of a burst
    send_frame(1'b1, 1'b1);
    n = 0;
    while (!(in_burst && (burst_len >= 10)) && (n < 200)) begin
      @(posedge clk);
      n++;
    end
    check("t6_burst_seen", 32'(n < 200), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t6_dv_async", 32'(dnn_dv_o), 32'd0);
    check("t6_frame_cnt", 32'(frame_cnt_o), 32'd0);
    check("t6_flags", {29'd0, ovf_o, timeout_o, dp_vad_o}, 32'd0);
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    send_frame(1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("t6_silent_after_reset", 32'(frame_cnt_o), 32'd0);
    send_frame(1'b1, 1'b1);
    wait_idle(400, "t6");
    check("t6_latency", 32'(first_dv_cyc), 32'(last_cyc + 2));
    check("t6_frame_cnt_next", 32'(frame_cnt_o), 32'd1);
    check("t6_drop", 32'(drop_cnt_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
